// File: rtl/multdiv_result_latch_pkg.sv
// Shared definitions for the mult/div return-side latch: IR field positions,
// ALU opcodes, exception codes and the FSM state encoding.
package multdiv_result_latch_pkg;

  // IR field positions
  localparam int unsigned IrRdMsb    = 26;
  localparam int unsigned IrRdLsb    = 22;
  localparam int unsigned IrAluopMsb = 6;
  localparam int unsigned IrAluopLsb = 2;

  // ALU opcodes that use the multi-cycle unit
  localparam logic [4:0] ALUOP_MULT = 5'b00110;
  localparam logic [4:0] ALUOP_DIV  = 5'b00111;

  // Value written to the status register on an exception
  localparam logic [31:0] EXC_CODE_MULT = 32'd4;
  localparam logic [31:0] EXC_CODE_DIV  = 32'd5;

  // Default status register index
  localparam logic [4:0] RSTATUS_REG_DEFAULT = 5'd30;

  // Width of the busy-cycle counter; saturates at all ones
  localparam int unsigned BusyCntW = 6;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic logic [4:0] ir_rd(logic [31:0] ir);
    return ir[IrRdMsb:IrRdLsb];
  endfunction

  function automatic logic [4:0] ir_aluop(logic [31:0] ir);
    return ir[IrAluopMsb:IrAluopLsb];
  endfunction

  // Exception code for the op in flight; non-mult/div opcodes should never
  // reach the unit, so they report 0.
  function automatic logic [31:0] exc_code(logic [31:0] ir);
    logic [31:0] code;
    code = 32'd0;
    if (ir_aluop(ir) == ALUOP_MULT) begin
      code = EXC_CODE_MULT;
    end else if (ir_aluop(ir) == ALUOP_DIV) begin
      code = EXC_CODE_DIV;
    end
    return code;
  endfunction

endpackage

// File: rtl/multdiv_result_latch_if.sv
// Bus between the pipeline/multdiv side and the result latch.
// master: pipeline + multdiv (drive start, results, accept)
// slave:  the result latch (drives stall, held result, status)
interface multdiv_result_latch_if;
  import multdiv_result_latch_pkg::*;

  logic                ctrl_multdiv;
  logic [31:0]         in_ir;
  logic [31:0]         data_result;
  logic                data_exception;
  logic                data_resultRDY;
  logic                wb_accept;

  logic                stall;
  logic                out_valid;
  logic [31:0]         out_result;
  logic [4:0]          out_rd;
  logic [31:0]         out_ir;
  logic [BusyCntW-1:0] busy_cycles;
  logic                err_timeout;
  logic                err_protocol;

  modport master (
    output ctrl_multdiv,
    output in_ir,
    output data_result,
    output data_exception,
    output data_resultRDY,
    output wb_accept,
    input  stall,
    input  out_valid,
    input  out_result,
    input  out_rd,
    input  out_ir,
    input  busy_cycles,
    input  err_timeout,
    input  err_protocol
  );

  modport slave (
    input  ctrl_multdiv,
    input  in_ir,
    input  data_result,
    input  data_exception,
    input  data_resultRDY,
    input  wb_accept,
    output stall,
    output out_valid,
    output out_result,
    output out_rd,
    output out_ir,
    output busy_cycles,
    output err_timeout,
    output err_protocol
  );

endinterface

// File: rtl/dffe_ref.sv
// Single-bit D flip-flop with synchronous active-high reset and enable.
module dffe_ref (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic d,
  output logic q
);

  // Reset wins over enable
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/multdiv_result_fsm.sv
// Control for the result latch: IDLE/BUSY/DONE sequencing, busy-cycle
// counter, sticky error flags and the capture enables for the data registers.
module multdiv_result_fsm
  import multdiv_result_latch_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = 40
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                result_rdy,
  input  logic                wb_accept,
  output logic                stall,
  output logic                out_valid,
  output logic                ir_en,
  output logic                res_en,
  output logic [BusyCntW-1:0] busy_cycles,
  output logic                err_timeout,
  output logic                err_protocol
);

  localparam logic [BusyCntW-1:0] CntMax = '1;

  state_e              state_q, state_d;
  logic [BusyCntW-1:0] cnt_q, cnt_d;
  logic                timeout_q, timeout_d;
  logic                proto_q, proto_d;

  // State, counter and sticky flag registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      proto_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      proto_q   <= proto_d;
    end
  end

  // Next-state, counter update, error detection and capture enables
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    proto_d   = proto_q;
    ir_en     = 1'b0;
    res_en    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Stray result-valid pulses are ignored here
        if (start) begin
          state_d = StBusy;
          ir_en   = 1'b1;
          cnt_d   = '0;
        end
      end

      StBusy: begin
        // A second start while an op is in flight is dropped and flagged
        if (start) begin
          proto_d = 1'b1;
        end
        if (result_rdy) begin
          state_d = StDone;
          res_en  = 1'b1;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
        // Flag rises on the same edge the counter reaches the limit
        if (32'(cnt_d) >= MAX_CYCLES) begin
          timeout_d = 1'b1;
        end
      end

      StDone: begin
        if (wb_accept) begin
          if (start) begin
            // Back-to-back op: writeback frees the slot this cycle
            state_d = StBusy;
            ir_en   = 1'b1;
            cnt_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end else if (start) begin
          // Held result must not be overwritten before writeback takes it
          proto_d = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Stall drops combinationally in the cycle writeback accepts
  always_comb begin
    out_valid = (state_q == StDone);
    stall     = (state_q == StBusy) | ((state_q == StDone) & ~wb_accept);
  end

  assign busy_cycles  = cnt_q;
  assign err_timeout  = timeout_q;
  assign err_protocol = proto_q;

endmodule

// File: rtl/multdiv_result_latch.sv
// Return-side latch for the multi-cycle mult/div unit. Holds the issuing IR,
// captures the result (or an exception code aimed at the status register)
// and keeps it until writeback accepts, stalling the front of the pipe
// for the whole window.
module multdiv_result_latch
  import multdiv_result_latch_pkg::*;
#(
  parameter int unsigned MAX_CYCLES  = 40,
  parameter logic [4:0]  RSTATUS_REG = RSTATUS_REG_DEFAULT
) (
  input logic                   clock,
  input logic                   reset,
  multdiv_result_latch_if.slave bus
);

  logic        ir_en;
  logic        res_en;
  logic [31:0] ir_q;
  logic [31:0] result_q;
  logic [4:0]  rd_q;
  logic [31:0] cap_result;
  logic [4:0]  cap_rd;

  multdiv_result_fsm #(
    .MAX_CYCLES (MAX_CYCLES)
  ) u_fsm (
    .clock        (clock),
    .reset        (reset),
    .start        (bus.ctrl_multdiv),
    .result_rdy   (bus.data_resultRDY),
    .wb_accept    (bus.wb_accept),
    .stall        (bus.stall),
    .out_valid    (bus.out_valid),
    .ir_en        (ir_en),
    .res_en       (res_en),
    .busy_cycles  (bus.busy_cycles),
    .err_timeout  (bus.err_timeout),
    .err_protocol (bus.err_protocol)
  );

  // Writeback target: exceptions redirect to the status register with a
  // per-opcode code, otherwise the multdiv result goes to IR rd.
  always_comb begin
    cap_result = bus.data_result;
    cap_rd     = ir_rd(ir_q);
    if (bus.data_exception) begin
      cap_result = exc_code(ir_q);
      cap_rd     = RSTATUS_REG;
    end
  end

  for (genvar i = 0; i < 32; i++) begin : g_ir
    dffe_ref u_ff (
      .clock (clock),
      .reset (reset),
      .en    (ir_en),
      .d     (bus.in_ir[i]),
      .q     (ir_q[i])
    );
  end

  for (genvar i = 0; i < 32; i++) begin : g_result
    dffe_ref u_ff (
      .clock (clock),
      .reset (reset),
      .en    (res_en),
      .d     (cap_result[i]),
      .q     (result_q[i])
    );
  end

  for (genvar i = 0; i < 5; i++) begin : g_rd
    dffe_ref u_ff (
      .clock (clock),
      .reset (reset),
      .en    (res_en),
      .d     (cap_rd[i]),
      .q     (rd_q[i])
    );
  end

  assign bus.out_ir     = ir_q;
  assign bus.out_result = result_q;
  assign bus.out_rd     = rd_q;

endmodule

// File: tb/tb_multdiv_result_latch.sv
// Directed bench for multdiv_result_latch: a table of complete ops plus
// hand-written sequences for back-to-back issue, protocol errors, reset
// mid-op and the busy timeout.
module tb_multdiv_result_latch;
  import multdiv_result_latch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multdiv_result_latch_if bus ();

  multdiv_result_latch #(
    .MAX_CYCLES  (40),
    .RSTATUS_REG (5'd30)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [31:0] ir;
    logic [31:0] result;
    logic        exc;
    int          wait_cyc;
    int          hold_cyc;
    logic [4:0]  exp_rd;
    logic [31:0] exp_result;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t vecs[5];

  function automatic logic [31:0] mk_ir(logic [4:0] rd, logic [4:0] aluop);
    return {5'b00000, rd, 5'd1, 5'd2, 5'd0, aluop, 2'b00};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ctrl_multdiv   = 1'b0;
    bus.in_ir          = 32'd0;
    bus.data_result    = 32'd0;
    bus.data_exception = 1'b0;
    bus.data_resultRDY = 1'b0;
    bus.wb_accept      = 1'b0;
  endtask

  // Full op: start, wait, result pulse, hold, accept
  task automatic run_op(input vec_t v, input int idx);
    int stall_cnt;
    stall_cnt = 0;
    bus.ctrl_multdiv = 1'b1;
    bus.in_ir        = v.ir;
    #1;
    check($sformatf("v%0d_idle_stall", idx), 32'(bus.stall), 32'd0);
    tick();
    bus.ctrl_multdiv = 1'b0;
    bus.in_ir        = ~v.ir;
    for (int i = 0; i < v.wait_cyc; i++) begin
      if (bus.stall) stall_cnt++;
      tick();
    end
    check($sformatf("v%0d_busy_cnt", idx), 32'(bus.busy_cycles), 32'(v.wait_cyc));
    check($sformatf("v%0d_busy_valid", idx), 32'(bus.out_valid), 32'd0);
    bus.data_resultRDY = 1'b1;
    bus.data_result    = v.result;
    bus.data_exception = v.exc;
    #1;
    if (bus.stall) stall_cnt++;
    tick();
    bus.data_resultRDY = 1'b0;
    bus.data_result    = 32'd0;
    bus.data_exception = 1'b0;
    #1;
    check($sformatf("v%0d_valid", idx), 32'(bus.out_valid), 32'd1);
    check($sformatf("v%0d_rd", idx), 32'(bus.out_rd), 32'(v.exp_rd));
    check($sformatf("v%0d_result", idx), bus.out_result, v.exp_result);
    check($sformatf("v%0d_ir", idx), bus.out_ir, v.ir);
    check($sformatf("v%0d_done_cnt", idx), 32'(bus.busy_cycles), 32'(v.wait_cyc));
    for (int h = 0; h < v.hold_cyc; h++) begin
      if (bus.stall) stall_cnt++;
      tick();
      check($sformatf("v%0d_hold_valid", idx), 32'(bus.out_valid), 32'd1);
      check($sformatf("v%0d_hold_result", idx), bus.out_result, v.exp_result);
      check($sformatf("v%0d_hold_rd", idx), 32'(bus.out_rd), 32'(v.exp_rd));
    end
    bus.wb_accept = 1'b1;
    #1;
    check($sformatf("v%0d_accept_stall", idx), 32'(bus.stall), 32'd0);
    check($sformatf("v%0d_stall_cycles", idx), 32'(stall_cnt),
          32'(v.wait_cyc + 1 + v.hold_cyc));
    tick();
    bus.wb_accept = 1'b0;
    #1;
    check($sformatf("v%0d_idle_valid", idx), 32'(bus.out_valid), 32'd0);
    check($sformatf("v%0d_idle_stall2", idx), 32'(bus.stall), 32'd0);
  endtask

  initial begin
    logic [31:0] ir_a;
    logic [31:0] ir_b;

    vecs[0] = '{mk_ir(5'd3, ALUOP_MULT), 32'h0000_0015, 1'b0, 32, 0, 5'd3, 32'h15};
    vecs[1] = '{mk_ir(5'd7, ALUOP_DIV), 32'h0000_dead, 1'b1, 5, 0, 5'd30, 32'd5};
    vecs[2] = '{mk_ir(5'd9, ALUOP_MULT), 32'h0000_beef, 1'b1, 3, 2, 5'd30, 32'd4};
    vecs[3] = '{mk_ir(5'd12, ALUOP_DIV), 32'h1234_5678, 1'b0, 0, 5, 5'd12, 32'h1234_5678};
    vecs[4] = '{mk_ir(5'd31, ALUOP_MULT), 32'hffff_ffff, 1'b0, 1, 1, 5'd31, 32'hffff_ffff};

    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result", bus.out_result, 32'd0);
    check("rst_rd", 32'(bus.out_rd), 32'd0);
    check("rst_ir", bus.out_ir, 32'd0);
    check("rst_busy", 32'(bus.busy_cycles), 32'd0);
    check("rst_err_to", 32'(bus.err_timeout), 32'd0);
    check("rst_err_pr", 32'(bus.err_protocol), 32'd0);

    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i], i);
    end
    check("table_err_pr", 32'(bus.err_protocol), 32'd0);
    check("table_err_to", 32'(bus.err_timeout), 32'd0);

    // Back-to-back: accept and new start in the same DONE cycle
    ir_a = mk_ir(5'd4, ALUOP_MULT);
    ir_b = mk_ir(5'd5, ALUOP_DIV);
    bus.ctrl_multdiv = 1'b1;
    bus.in_ir        = ir_a;
    tick();
    bus.ctrl_multdiv = 1'b0;
    tick();
    tick();
    bus.data_resultRDY = 1'b1;
    bus.data_result    = 32'h0000_0042;
    tick();
    bus.data_resultRDY = 1'b0;
    #1;
    check("b2b_first_valid", 32'(bus.out_valid), 32'd1);
    check("b2b_first_result", bus.out_result, 32'h42);
    bus.wb_accept    = 1'b1;
    bus.ctrl_multdiv = 1'b1;
    bus.in_ir        = ir_b;
    tick();
    bus.wb_accept    = 1'b0;
    bus.ctrl_multdiv = 1'b0;
    bus.in_ir        = 32'd0;
    #1;
    check("b2b_stall", 32'(bus.stall), 32'd1);
    check("b2b_valid", 32'(bus.out_valid), 32'd0);
    check("b2b_ir", bus.out_ir, ir_b);
    check("b2b_busy", 32'(bus.busy_cycles), 32'd0);
    check("b2b_err_pr", 32'(bus.err_protocol), 32'd0);
    tick();
    bus.data_resultRDY = 1'b1;
    bus.data_result    = 32'h0000_0077;
    tick();
    bus.data_resultRDY = 1'b0;
    #1;
    check("b2b_second_rd", 32'(bus.out_rd), 32'd5);
    check("b2b_second_result", bus.out_result, 32'h77);
    bus.wb_accept = 1'b1;
    tick();
    bus.wb_accept = 1'b0;

    // Stray result pulse in IDLE
    bus.data_resultRDY = 1'b1;
    bus.data_result    = 32'h0bad_0bad;
    tick();
    bus.data_resultRDY = 1'b0;
    #1;
    check("stray_valid", 32'(bus.out_valid), 32'd0);
    check("stray_stall", 32'(bus.stall), 32'd0);
    check("stray_result", bus.out_result, 32'h77);
    check("stray_err_pr", 32'(bus.err_protocol), 32'd0);

    // Start while BUSY, then start in DONE without accept
    ir_a = mk_ir(5'd8, ALUOP_MULT);
    ir_b = mk_ir(5'd9, ALUOP_DIV);
    bus.ctrl_multdiv = 1'b1;
    bus.in_ir        = ir_a;
    tick();
    bus.in_ir = ir_b;
    tick();
    bus.ctrl_multdiv = 1'b0;
    #1;
    check("busy_start_err_pr", 32'(bus.err_protocol), 32'd1);
    check("busy_start_ir", bus.out_ir, ir_a);
    check("busy_start_stall", 32'(bus.stall), 32'd1);
    check("busy_start_cnt", 32'(bus.busy_cycles), 32'd1);
    bus.data_resultRDY = 1'b1;
    bus.data_result    = 32'h0000_0099;
    tick();
    bus.data_resultRDY = 1'b0;
    bus.ctrl_multdiv   = 1'b1;
    tick();
    bus.ctrl_multdiv = 1'b0;
    #1;
    check("done_start_valid", 32'(bus.out_valid), 32'd1);
    check("done_start_result", bus.out_result, 32'h99);
    check("done_start_rd", 32'(bus.out_rd), 32'd8);
    check("done_start_ir", bus.out_ir, ir_a);
    bus.wb_accept = 1'b1;
    tick();
    bus.wb_accept = 1'b0;
    #1;
    check("done_start_idle", 32'(bus.out_valid), 32'd0);

    // Reset at BUSY cycle 10
    bus.ctrl_multdiv = 1'b1;
    bus.in_ir        = mk_ir(5'd6, ALUOP_DIV);
    tick();
    bus.ctrl_multdiv = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("pre_rst_busy", 32'(bus.busy_cycles), 32'd10);
    check("pre_rst_stall", 32'(bus.stall), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_stall", 32'(bus.stall), 32'd0);
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_ir", bus.out_ir, 32'd0);
    check("mid_rst_result", bus.out_result, 32'd0);
    check("mid_rst_busy", 32'(bus.busy_cycles), 32'd0);
    check("mid_rst_err_pr", 32'(bus.err_protocol), 32'd0);

    // Timeout: no result for 40 BUSY cycles, then saturation
    bus.ctrl_multdiv = 1'b1;
    bus.in_ir        = mk_ir(5'd2, ALUOP_MULT);
    tick();
    bus.ctrl_multdiv = 1'b0;
    for (int i = 0; i < 39; i++) tick();
    check("to_39_cnt", 32'(bus.busy_cycles), 32'd39);
    check("to_39_flag", 32'(bus.err_timeout), 32'd0);
    tick();
    check("to_40_cnt", 32'(bus.busy_cycles), 32'd40);
    check("to_40_flag", 32'(bus.err_timeout), 32'd1);
    check("to_40_stall", 32'(bus.stall), 32'd1);
    for (int i = 0; i < 30; i++) tick();
    check("to_sat_cnt", 32'(bus.busy_cycles), 32'd63);
    bus.data_resultRDY = 1'b1;
    bus.data_result    = 32'h0000_0123;
    tick();
    bus.data_resultRDY = 1'b0;
    #1;
    check("to_late_valid", 32'(bus.out_valid), 32'd1);
    check("to_late_result", bus.out_result, 32'h123);
    bus.wb_accept = 1'b1;
    tick();
    bus.wb_accept = 1'b0;
    #1;
    check("to_sticky", 32'(bus.err_timeout), 32'd1);
    check("to_idle_stall", 32'(bus.stall), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
